// File: rtl/id_decode_queue.sv
// -----------------------------------------------------------------------------
// id_decode_queue
//   Instruction decode stage with a DEPTH-entry input queue. Fetched words are
//   buffered; the head entry is decoded combinationally and captured into a
//   registered output bundle behind a valid/ready handshake. Supports RV32 or
//   RV64 (XLEN), flags unsupported encodings as illegal, and can be flushed.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               discard queue contents and the output bundle
//   if_valid/if_ready   fetch-side handshake; inst/inst_addr are the payload
//   id_valid/id_ready   execute-side handshake for the decoded bundle
//   id_pc .. illegal    decoded bundle (registered)
//   count               queue occupancy (excluding the output register)
// -----------------------------------------------------------------------------
module id_decode_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  inst_addr,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [10:0]      op_class,
    output logic [2:0]       func3,
    output logic             alt,
    output logic             is_word,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    output logic [4:0]       rd_addr,
    output logic             rd_w_ena,
    output logic [XLEN-1:0]  imm,
    output logic             illegal,
    output logic [CNT_W-1:0] count
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
    localparam logic             IS_RV32 = (XLEN == 32);

    // one-hot positions inside op_class
    localparam int C_LOAD   = 0;
    localparam int C_STORE  = 1;
    localparam int C_ALUI   = 2;
    localparam int C_ALUR   = 3;
    localparam int C_BRANCH = 4;
    localparam int C_JAL    = 5;
    localparam int C_JALR   = 6;
    localparam int C_LUI    = 7;
    localparam int C_AUIPC  = 8;
    localparam int C_SYSTEM = 9;
    localparam int C_FENCE  = 10;

    logic [31:0]      r_q_inst [DEPTH];
    logic [XLEN-1:0]  r_q_pc   [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             r_id_valid;
    logic [XLEN-1:0]  r_id_pc;
    logic [10:0]      r_op_class;
    logic [2:0]       r_func3;
    logic             r_alt;
    logic             r_is_word;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_rd_w_ena;
    logic [XLEN-1:0]  r_imm;
    logic             r_illegal;

    logic             w_push;
    logic             w_load;
    logic [31:0]      w_h_inst;
    logic [XLEN-1:0]  w_h_pc;
    logic [6:0]       w_opc;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic [10:0]      w_op;
    logic             w_rs1_use;
    logic             w_rs2_use;
    logic             w_rd_use;
    logic [XLEN-1:0]  w_imm;
    logic             w_bad;

    assign if_ready = (r_count != FULL) & ~rst;
    assign w_push   = if_valid & if_ready;
    assign w_load   = (~r_id_valid | id_ready) & (r_count != {CNT_W{1'b0}});

    assign w_h_inst = r_q_inst[r_head];
    assign w_h_pc   = r_q_pc[r_head];
    assign w_opc    = w_h_inst[6:0];
    assign w_f3     = w_h_inst[14:12];
    assign w_f7     = w_h_inst[31:25];

    // Queue storage: payload only, no reset needed since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_tail] <= inst;
            r_q_pc[r_tail]   <= inst_addr;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_load) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Combinational decode of the queue head.
    always_comb begin
        w_op      = 11'd0;
        w_rs1_use = 1'b0;
        w_rs2_use = 1'b0;
        w_rd_use  = 1'b0;
        w_imm     = {XLEN{1'b0}};
        w_bad     = 1'b0;
        case (w_opc)
            7'h03: begin
                w_op[C_LOAD] = 1'b1;
                w_rs1_use    = 1'b1;
                w_rd_use     = 1'b1;
                w_imm        = XLEN'($signed(w_h_inst[31:20]));
                if ((w_f3 == 3'd7) || (IS_RV32 && ((w_f3 == 3'd3) || (w_f3 == 3'd6)))) begin
                    w_bad = 1'b1;
                end else begin
                    w_bad = 1'b0;
                end
            end
            7'h23: begin
                w_op[C_STORE] = 1'b1;
                w_rs1_use     = 1'b1;
                w_rs2_use     = 1'b1;
                w_imm         = XLEN'($signed({w_h_inst[31:25], w_h_inst[11:7]}));
                if ((w_f3 > 3'd3) || (IS_RV32 && (w_f3 == 3'd3))) begin
                    w_bad = 1'b1;
                end else begin
                    w_bad = 1'b0;
                end
            end
            7'h13, 7'h1b: begin
                w_op[C_ALUI] = 1'b1;
                w_rs1_use    = 1'b1;
                w_rd_use     = 1'b1;
                w_imm        = XLEN'($signed(w_h_inst[31:20]));
                // RV32 has no word ops, and shamt is only 5 bits wide
                if (IS_RV32 && ((w_opc == 7'h1b) ||
                    (((w_f3 == 3'd1) || (w_f3 == 3'd5)) && w_h_inst[25]))) begin
                    w_bad = 1'b1;
                end else begin
                    w_bad = 1'b0;
                end
            end
            7'h33, 7'h3b: begin
                w_op[C_ALUR] = 1'b1;
                w_rs1_use    = 1'b1;
                w_rs2_use    = 1'b1;
                w_rd_use     = 1'b1;
                if ((w_f7 != 7'h00) && (w_f7 != 7'h20)) begin
                    w_bad = 1'b1;
                end else if ((w_f7 == 7'h20) && (w_f3 != 3'd0) && (w_f3 != 3'd5)) begin
                    w_bad = 1'b1;
                end else if (IS_RV32 && (w_opc == 7'h3b)) begin
                    w_bad = 1'b1;
                end else begin
                    w_bad = 1'b0;
                end
            end
            7'h63: begin
                w_op[C_BRANCH] = 1'b1;
                w_rs1_use      = 1'b1;
                w_rs2_use      = 1'b1;
                w_imm          = XLEN'($signed({w_h_inst[31], w_h_inst[7], w_h_inst[30:25],
                                                w_h_inst[11:8], 1'b0}));
                w_bad          = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            7'h6f: begin
                w_op[C_JAL] = 1'b1;
                w_rd_use    = 1'b1;
                w_imm       = XLEN'($signed({w_h_inst[31], w_h_inst[19:12], w_h_inst[20],
                                             w_h_inst[30:21], 1'b0}));
            end
            7'h67: begin
                w_op[C_JALR] = 1'b1;
                w_rs1_use    = 1'b1;
                w_rd_use     = 1'b1;
                w_imm        = XLEN'($signed(w_h_inst[31:20]));
            end
            7'h37: begin
                w_op[C_LUI] = 1'b1;
                w_rd_use    = 1'b1;
                w_imm       = XLEN'($signed({w_h_inst[31:12], 12'd0}));
            end
            7'h17: begin
                w_op[C_AUIPC] = 1'b1;
                w_rd_use      = 1'b1;
                w_imm         = XLEN'($signed({w_h_inst[31:12], 12'd0}));
            end
            7'h73: begin
                w_op[C_SYSTEM] = 1'b1;
                w_imm          = XLEN'(w_h_inst[31:20]);
                if (w_f3 == 3'd0) begin
                    // only ecall, ebreak and mret are supported
                    w_bad = (w_h_inst[31:20] != 12'h000) && (w_h_inst[31:20] != 12'h001) &&
                            (w_h_inst[31:20] != 12'h302);
                end else if (w_f3[1:0] != 2'b00) begin
                    // CSR ops; rs1 is a register only for the non-immediate forms
                    w_rd_use  = 1'b1;
                    w_rs1_use = ~w_f3[2];
                end else begin
                    w_bad = 1'b0;
                end
            end
            7'h0f: begin
                w_op[C_FENCE] = 1'b1;
            end
            default: begin
                w_bad = 1'b1;
            end
        endcase
        if (w_bad) begin
            w_op      = 11'd0;
            w_rs1_use = 1'b0;
            w_rs2_use = 1'b0;
            w_rd_use  = 1'b0;
            w_imm     = {XLEN{1'b0}};
        end else begin
            w_op = w_op;
        end
    end

    // Output bundle register: captures the decoded head on load, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid <= 1'b0;
            r_id_pc    <= {XLEN{1'b0}};
            r_op_class <= 11'd0;
            r_func3    <= 3'd0;
            r_alt      <= 1'b0;
            r_is_word  <= 1'b0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_rd_w_ena <= 1'b0;
            r_imm      <= {XLEN{1'b0}};
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_id_valid <= 1'b0;
        end else if (w_load) begin
            r_id_valid <= 1'b1;
            r_id_pc    <= w_h_pc;
            r_op_class <= w_op;
            r_func3    <= w_f3;
            r_alt      <= w_h_inst[30];
            r_is_word  <= (w_opc == 7'h1b) || (w_opc == 7'h3b);
            r_rs1      <= w_rs1_use ? w_h_inst[19:15] : 5'd0;
            r_rs2      <= w_rs2_use ? w_h_inst[24:20] : 5'd0;
            r_rd       <= w_rd_use  ? w_h_inst[11:7]  : 5'd0;
            r_rd_w_ena <= w_rd_use;
            r_imm      <= w_imm;
            r_illegal  <= w_bad;
        end else if (id_ready) begin
            r_id_valid <= 1'b0;
        end
    end

    assign id_valid = r_id_valid;
    assign id_pc    = r_id_pc;
    assign op_class = r_op_class;
    assign func3    = r_func3;
    assign alt      = r_alt;
    assign is_word  = r_is_word;
    assign rs1_addr = r_rs1;
    assign rs2_addr = r_rs2;
    assign rd_addr  = r_rd;
    assign rd_w_ena = r_rd_w_ena;
    assign imm      = r_imm;
    assign illegal  = r_illegal;
    assign count    = r_count;

endmodule

// File: tb/tb_id_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_id_decode_queue
//   Scoreboard bench for id_decode_queue. An RV64 and an RV32 instance share
//   the same stimulus; expected bundles are queued at push time and popped by
//   per-instance monitors whenever a bundle is accepted.
// -----------------------------------------------------------------------------
module tb_id_decode_queue;
    typedef struct packed {
        logic [63:0] pc;
        logic [10:0] op;
        logic [2:0]  f3;
        logic        alt;
        logic        w;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [63:0] imm;
        logic        ill;
    } bun_t;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready;
    logic [31:0] inst;
    logic [63:0] inst_addr;

    logic        d_if_ready, d_id_valid, d_alt, d_is_word, d_we, d_ill;
    logic [63:0] d_id_pc, d_imm;
    logic [10:0] d_op;
    logic [2:0]  d_f3, d_count;
    logic [4:0]  d_rs1, d_rs2, d_rd;

    logic        s_if_ready, s_id_valid, s_alt, s_is_word, s_we, s_ill;
    logic [31:0] s_id_pc, s_imm;
    logic [10:0] s_op;
    logic [2:0]  s_f3, s_count;
    logic [4:0]  s_rs1, s_rs2, s_rd;

    int   checks = 0;
    int   errors = 0;
    bun_t q64[$];
    bun_t q32[$];
    bun_t g64, g32, zero_b;

    always #5 clk = ~clk;

    id_decode_queue #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(d_if_ready),
        .inst(inst), .inst_addr(inst_addr), .id_valid(d_id_valid), .id_ready(id_ready),
        .id_pc(d_id_pc), .op_class(d_op), .func3(d_f3), .alt(d_alt), .is_word(d_is_word),
        .rs1_addr(d_rs1), .rs2_addr(d_rs2), .rd_addr(d_rd), .rd_w_ena(d_we), .imm(d_imm),
        .illegal(d_ill), .count(d_count)
    );

    id_decode_queue #(.XLEN(32), .DEPTH(4)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(s_if_ready),
        .inst(inst), .inst_addr(inst_addr[31:0]), .id_valid(s_id_valid), .id_ready(id_ready),
        .id_pc(s_id_pc), .op_class(s_op), .func3(s_f3), .alt(s_alt), .is_word(s_is_word),
        .rs1_addr(s_rs1), .rs2_addr(s_rs2), .rd_addr(s_rd), .rd_w_ena(s_we), .imm(s_imm),
        .illegal(s_ill), .count(s_count)
    );

    assign g64    = {d_id_pc, d_op, d_f3, d_alt, d_is_word, d_rs1, d_rs2, d_rd, d_we, d_imm, d_ill};
    assign g32    = {32'd0, s_id_pc, s_op, s_f3, s_alt, s_is_word, s_rs1, s_rs2, s_rd, s_we,
                     32'd0, s_imm, s_ill};
    assign zero_b = '0;

    task automatic chk_b(input string name, input bun_t got, input bun_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic bun_t mk(input logic [63:0] pc, input logic [10:0] op, input logic [2:0] f3,
                                input logic alt, input logic w, input logic [4:0] r1,
                                input logic [4:0] r2, input logic [4:0] rd, input logic we,
                                input logic [63:0] im, input logic ill);
        bun_t b;
        b = {pc, op, f3, alt, w, r1, r2, rd, we, im, ill};
        return b;
    endfunction

    function automatic bun_t lo32(input bun_t b);
        bun_t r;
        r = b;
        r.pc[63:32]  = 32'd0;
        r.imm[63:32] = 32'd0;
        return r;
    endfunction

    function automatic bun_t illb(input logic [63:0] pc, input logic [2:0] f3, input logic alt,
                                  input logic w);
        return mk(pc & 64'h0000_0000_FFFF_FFFF, 11'd0, f3, alt, w, 5'd0, 5'd0, 5'd0, 1'b0,
                  64'd0, 1'b1);
    endfunction

    // RV64 monitor: scoreboard pop on accept, plus stability while stalled
    bun_t prev64;
    logic stall64   = 1'b0;
    logic prevctl64 = 1'b0;
    always @(negedge clk) begin
        if (stall64 && !prevctl64) begin
            chk_b("stall_hold64", g64, prev64);
        end
        if (d_id_valid && id_ready) begin
            if (q64.size() == 0) begin
                chk_b("unexpected64", g64, zero_b);
                checks++;
                errors++;
                $display("FAIL unexpected64: got bundle with no expectation pending");
            end else begin
                chk_b("bundle64", g64, q64.pop_front());
            end
        end
        stall64   <= d_id_valid && !id_ready;
        prev64    <= g64;
        prevctl64 <= rst || flush;
    end

    // RV32 monitor: scoreboard pop on accept
    always @(negedge clk) begin
        if (s_id_valid && id_ready) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected32: got bundle with no expectation pending");
            end else begin
                chk_b("bundle32", g32, q32.pop_front());
            end
        end
    end

    task automatic push(input logic [31:0] w, input logic [63:0] pc, input bit rec,
                        input bun_t e64, input bun_t e32);
        bit done;
        done      = 1'b0;
        if_valid  = 1'b1;
        inst      = w;
        inst_addr = pc;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = d_if_ready;
            @(posedge clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: if_ready stayed 0 for pc %h", pc);
        end else if (rec) begin
            q64.push_back(e64);
            q32.push_back(e32);
        end
        #1;
        if_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q64.size() != 0 || q32.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q64.size() != 0 || q32.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d/%0d bundles never delivered", q64.size(), q32.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk_b({tag, "_bundle64"}, g64, zero_b);
        chk_b({tag, "_bundle32"}, g32, zero_b);
        chk_v({tag, "_valid"}, {62'd0, d_id_valid, s_id_valid}, 64'd0);
        chk_v({tag, "_count"}, {58'd0, d_count, s_count}, 64'd0);
        chk_v({tag, "_if_ready"}, {62'd0, d_if_ready, s_if_ready}, 64'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [63:0] pc;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        inst = 32'd0; inst_addr = 64'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state("reset");
        @(posedge clk);
        #1;

        // addi x1,x0,5: latency of two edges
        id_ready = 1'b1;
        push(32'h0050_0093, 64'h100, 1'b1,
             mk(64'h100, 11'h004, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 64'd5, 1'b0),
             mk(64'h100, 11'h004, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd1, 1'b1, 64'd5, 1'b0));
        chk_v("latency_edge1", {63'd0, d_id_valid}, 64'd0);
        @(posedge clk);
        #1;
        chk_v("latency_edge2", {63'd0, d_id_valid}, 64'd1);
        drain();

        // back-to-back decode vectors
        push(32'h0080_B103, 64'h104, 1'b1,
             mk(64'h104, 11'h001, 3'd3, 1'b0, 1'b0, 5'd1, 5'd0, 5'd2, 1'b1, 64'd8, 1'b0),
             illb(64'h104, 3'd3, 1'b0, 1'b0));
        push(32'hFE00_0EE3, 64'h108, 1'b1,
             mk(64'h108, 11'h010, 3'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFC, 1'b0),
             lo32(mk(64'h108, 11'h010, 3'd0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0,
                     64'hFFFF_FFFF_FFFF_FFFC, 1'b0)));
        push(32'h8000_02B7, 64'h10C, 1'b1,
             mk(64'h10C, 11'h080, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1,
                64'hFFFF_FFFF_8000_0000, 1'b0),
             lo32(mk(64'h10C, 11'h080, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1,
                     64'hFFFF_FFFF_8000_0000, 1'b0)));
        push(32'h0031_3823, 64'h110, 1'b1,
             mk(64'h110, 11'h002, 3'd3, 1'b0, 1'b0, 5'd2, 5'd3, 5'd0, 1'b0, 64'd16, 1'b0),
             illb(64'h110, 3'd3, 1'b0, 1'b0));
        push(32'h4073_02B3, 64'h114, 1'b1,
             mk(64'h114, 11'h008, 3'd0, 1'b1, 1'b0, 5'd6, 5'd7, 5'd5, 1'b1, 64'd0, 1'b0),
             mk(64'h114, 11'h008, 3'd0, 1'b1, 1'b0, 5'd6, 5'd7, 5'd5, 1'b1, 64'd0, 1'b0));
        push(32'h4073_12B3, 64'h118, 1'b1,
             illb(64'h118, 3'd1, 1'b1, 1'b0), illb(64'h118, 3'd1, 1'b1, 1'b0));
        push(32'h3020_0073, 64'h11C, 1'b1,
             mk(64'h11C, 11'h200, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h302, 1'b0),
             mk(64'h11C, 11'h200, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h302, 1'b0));
        push(32'h0020_0073, 64'h120, 1'b1,
             illb(64'h120, 3'd0, 1'b0, 1'b0), illb(64'h120, 3'd0, 1'b0, 1'b0));
        drain();

        // stall with DEPTH+1 pushes, then drain one per cycle
        id_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            w  = (32'(k) << 20) | (32'(k) << 7) | 32'h13;
            pc = 64'h200 + 64'(4 * k);
            push(w, pc, 1'b1,
                 mk(pc, 11'h004, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'(k), 1'b1, 64'(k), 1'b0),
                 mk(pc, 11'h004, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'(k), 1'b1, 64'(k), 1'b0));
        end
        @(negedge clk);
        chk_v("full_count", {61'd0, d_count}, 64'd4);
        chk_v("full_if_ready", {62'd0, d_if_ready, s_if_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1 id_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_v("drain_rate", {63'd0, d_id_valid}, 64'd1);
        end
        @(negedge clk);
        chk_v("drain_done", {63'd0, d_id_valid}, 64'd0);
        drain();

        // fill, then flush together with a push
        id_ready = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            push((32'(k) << 7) | 32'h13, 64'h500 + 64'(4 * k), 1'b0, zero_b, zero_b);
        end
        @(posedge clk);
        #1;
        flush = 1'b1; if_valid = 1'b1; inst = 32'h0010_0093; inst_addr = 64'h999;
        @(posedge clk);
        #1 flush = 1'b0; if_valid = 1'b0;
        @(negedge clk);
        chk_v("flush_count", {58'd0, d_count, s_count}, 64'd0);
        chk_v("flush_valid", {62'd0, d_id_valid, s_id_valid}, 64'd0);
        chk_v("flush_if_ready", {62'd0, d_if_ready, s_if_ready}, 64'd3);
        @(posedge clk);
        #1 id_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push(32'h0000_007B, 64'h400, 1'b1,
             illb(64'h400, 3'd0, 1'b0, 1'b0), illb(64'h400, 3'd0, 1'b0, 1'b0));
        drain();

        // reset with three entries queued
        id_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            push(32'h0000_0013, 64'h600 + 64'(4 * k), 1'b0, zero_b, zero_b);
        end
        @(negedge clk);
        chk_v("pre_reset_count", {58'd0, d_count, s_count}, 64'h1B);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_v("reset_if_ready_low", {62'd0, d_if_ready, s_if_ready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state("midreset");
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
